// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR scheduler: FSM state encoding,
// default LFSR width/seed and the feedback tap positions.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_SEED  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  localparam int LFSR_W = 12;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 12'hC0D;

  // Taps of x^12 + x^6 + x^4 + x + 1 as seen from the shift-left register.
  localparam int TAP0 = 0;
  localparam int TAP1 = 3;
  localparam int TAP2 = 5;
  localparam int TAP3 = 11;

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step advance of the shift-left Fibonacci LFSR.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int N = LFSR_W
) (
  input  logic [N-1:0] cur_i,
  output logic [N-1:0] nxt_o
);

  assign nxt_o = {cur_i[N-2:0], cur_i[TAP0] ^ cur_i[TAP1] ^ cur_i[TAP2] ^ cur_i[TAP3]};

endmodule

// File: rtl/lfsr_sched.sv
// Round-robin scheduler issuing successive words of one shared LFSR, one word per grant.
// Define LFSR_SCHED_TICK_EN to build the step counter and the period_tick output.
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int N = LFSR_W,
  parameter int NREQ = 4,
  parameter logic [N-1:0] SEED = LFSR_SEED
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [N-1:0]    seed_in,
  output logic [NREQ-1:0] gnt,
  output logic [N-1:0]    rnd_data,
  output logic            rnd_valid,
  output logic            seed_err,
  output logic            period_tick
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  state_e          state_q;
  logic [N-1:0]    lfsr_q;
  logic [N-1:0]    lfsr_d;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] gnt_d;
  logic [N-1:0]    rnd_data_q;
  logic            seed_err_q;
  logic            seed_zero;

  logic [NREQ-1:0] elig;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   win_idx;
  logic            win_found;

  lfsr_step #(.N(N)) u_step (
    .cur_i (lfsr_q),
    .nxt_o (lfsr_d)
  );

  assign seed_zero = (seed_in == '0);

  // A requester granted this cycle is masked so it cannot win twice in a row.
  always_comb begin
    elig      = req & ~gnt_q;
    cand      = ptr_q;
    win_idx   = ptr_q;
    win_found = 1'b0;
    gnt_d     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == PTR_LAST) ? '0 : cand + 1'b1;
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    if (win_found) begin
      gnt_d[win_idx] = 1'b1;
    end
  end

  // The SEED cycle itself never grants; a request pending at its end is
  // granted straight away so the loaded seed is issued on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SEED;
      lfsr_q     <= SEED;
      ptr_q      <= PTR_LAST;
      gnt_q      <= '0;
      rnd_data_q <= '0;
      seed_err_q <= 1'b0;
    end else begin
      gnt_q      <= '0;
      seed_err_q <= 1'b0;
      if (seed_load) begin
        state_q    <= ST_SEED;
        lfsr_q     <= seed_zero ? SEED : seed_in;
        seed_err_q <= seed_zero;
      end else if (win_found) begin
        state_q    <= ST_GRANT;
        gnt_q      <= gnt_d;
        rnd_data_q <= lfsr_q;
        lfsr_q     <= lfsr_d;
        ptr_q      <= win_idx;
      end else begin
        state_q    <= ST_IDLE;
      end
    end
  end

  assign gnt       = gnt_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_valid = (state_q == ST_GRANT);
  assign seed_err  = seed_err_q;

`ifdef LFSR_SCHED_TICK_EN
  localparam logic [N-1:0] CNT_LAST = {{(N-1){1'b1}}, 1'b0};

  logic [N-1:0] cnt_q;
  logic         tick_q;

  // Counts grants since reset/seed load; wraps after 2^N-1 grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (seed_load) begin
        cnt_q <= '0;
      end else if (win_found) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign period_tick = tick_q;
`else
  assign period_tick = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed bench for lfsr_sched: a behavioural model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_lfsr_sched;

  localparam int N    = 12;
  localparam int NREQ = 4;
`ifdef LFSR_SCHED_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            seed_load = 1'b0;
  logic [N-1:0]    seed_in = '0;
  logic [NREQ-1:0] gnt;
  logic [N-1:0]    rnd_data;
  logic            rnd_valid;
  logic            seed_err;
  logic            period_tick;

  always #5 clk = ~clk;

  lfsr_sched #(.N(N), .NREQ(NREQ), .SEED(12'hC0D)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .gnt         (gnt),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .seed_err    (seed_err),
    .period_tick (period_tick)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words come from a plain polynomial step, winners from a modular scan.
  logic [N-1:0]    m_lfsr = 12'hC0D;
  int              m_ptr = NREQ - 1;
  logic [NREQ-1:0] m_gnt = '0;
  logic [N-1:0]    m_data = '0;
  logic            m_err = 1'b0;
  logic            m_tick = 1'b0;
  int              m_steps = 0;
  int              grant_no = 0;
  logic [NREQ-1:0] m_elig;
  int              m_win;
  bit              long_run = 1'b0;

  function automatic logic [N-1:0] next_word(input logic [N-1:0] w);
    return {w[N-2:0], w[0] ^ w[3] ^ w[5] ^ w[11]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr = 12'hC0D; m_ptr = NREQ - 1; m_gnt = '0; m_data = '0;
      m_err = 1'b0; m_tick = 1'b0; m_steps = 0; grant_no = 0;
    end else begin
      m_elig = req & ~m_gnt;
      m_gnt  = '0;
      m_err  = 1'b0;
      m_tick = 1'b0;
      if (seed_load) begin
        m_err   = (seed_in == '0);
        m_lfsr  = m_err ? 12'hC0D : seed_in;
        m_steps = 0;
      end else begin
        m_win = -1;
        for (int k = 1; k <= NREQ; k++)
          if (m_win < 0 && ((m_elig >> ((m_ptr + k) % NREQ)) & 1) != 0)
            m_win = (m_ptr + k) % NREQ;
        if (m_win >= 0) begin
          m_gnt  = NREQ'(1) << m_win;
          m_data = m_lfsr;
          m_lfsr = next_word(m_lfsr);
          m_ptr  = m_win;
          grant_no++;
          m_steps++;
          if (m_steps == (1 << N) - 1) begin
            m_tick  = TICK_ON;
            m_steps = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("rnd_valid", 32'(rnd_valid), 32'(|m_gnt));
    if (m_gnt != '0) check("rnd_data", 32'(rnd_data), 32'(m_data));
    check("seed_err", 32'(seed_err), 32'(m_err));
    check("period_tick", 32'(period_tick), 32'(m_tick));
    if (long_run && m_gnt != '0) begin
      if (grant_no == 4095) check("tick_on_grant_4095", 32'(period_tick), 32'(TICK_ON));
      if (grant_no == 4096) check("word_of_grant_4096", 32'(rnd_data), 32'h0C0D);
    end
  end

  // Requesters hold req through their grant cycle and drop it on the next;
  // with auto set, a dropped request comes back one cycle later.
  logic [NREQ-1:0] pend = '0;
  logic [NREQ-1:0] last_drop = '0;
  bit              auto = 1'b0;

  task automatic step();
    logic [NREQ-1:0] g;
    g = m_gnt;
    @(posedge clk);
    #1;
    pend      = (pend & ~g) | (auto ? last_drop : '0);
    last_drop = g;
    req       = pend;
    seed_load = 1'b0;
  endtask

  task automatic load_seed(input logic [N-1:0] s);
    seed_in   = s;
    seed_load = 1'b1;
  endtask

  task automatic reset_with(input logic [NREQ-1:0] p, input bit a);
    reset = 1'b1;
    long_run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pend = p; req = p; auto = a; last_drop = '0; seed_load = 1'b0;
    reset = 1'b0;
  endtask

  logic [NREQ-1:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0]    rr_dat [5] = '{12'hC0D, 12'h81B, 12'h037, 12'h06E, 12'h0DC};

  initial begin
    // Reset state, then a single requester.
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_valid", 32'(rnd_valid), 32'd0);
    check("reset_data", 32'(rnd_data), 32'd0);
    check("reset_seed_err", 32'(seed_err), 32'd0);
    check("reset_tick", 32'(period_tick), 32'd0);
    pend = 4'b0001; req = pend; reset = 1'b0;
    step();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_word", 32'(rnd_data), 32'h0C0D);
    step();
    check("masked_after_grant", 32'(gnt), 32'h0);
    pend = 4'b0001; req = pend;
    step();
    check("second_word", 32'(rnd_data), 32'h081B);
    step();
    pend = 4'b0001; req = pend;
    step();
    check("third_word", 32'(rnd_data), 32'h0037);

    // All four requesting: consecutive round-robin grants.
    reset_with(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_gnt", 32'(gnt), 32'(rr_gnt[i]));
      check("rr_word", 32'(rnd_data), 32'(rr_dat[i]));
    end
    auto = 1'b0; pend = '0; req = '0;
    repeat (3) step();

    // Seed load colliding with pending requests 1 and 2 (ptr is at 0).
    pend = 4'b0110; req = pend;
    load_seed(12'h001);
    step();
    check("seed_cycle_gnt", 32'(gnt), 32'h0);
    check("seed_cycle_err", 32'(seed_err), 32'h0);
    step();
    check("seed_gnt_r1", 32'(gnt), 32'h2);
    check("seed_word", 32'(rnd_data), 32'h001);
    step();
    check("seed_gnt_r2", 32'(gnt), 32'h4);
    check("seed_word2", 32'(rnd_data), 32'h003);
    repeat (2) step();

    // All-zero seed falls back to C0D.
    load_seed(12'h000);
    step();
    check("zero_seed_err", 32'(seed_err), 32'h1);
    step();
    check("zero_seed_err_clear", 32'(seed_err), 32'h0);
    pend = 4'b1000; req = pend;
    step();
    check("zero_seed_gnt", 32'(gnt), 32'h8);
    check("zero_seed_word", 32'(rnd_data), 32'h0C0D);
    repeat (2) step();

    // Full LFSR period from reset.
    reset_with(4'b1111, 1'b1);
    long_run = 1'b1;
    for (int c = 0; c < 5000 && grant_no < 4097; c++) step();
    check("long_run_reached", 32'(grant_no >= 4097), 32'd1);
    long_run = 1'b0;

    // Asynchronous reset in the middle of a grant cycle.
    for (int c = 0; c < 4 && m_gnt == '0; c++) step();
    check("gnt_before_reset", 32'(|gnt), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_valid", 32'(rnd_valid), 32'd0);
    @(posedge clk);
    #1;
    pend = 4'b0001; req = pend; auto = 1'b0; last_drop = '0;
    reset = 1'b0;
    step();
    check("post_reset_gnt", 32'(gnt), 32'h1);
    check("post_reset_word", 32'(rnd_data), 32'h0C0D);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
